// File: rtl/spi_download_pkg.sv
// Shared command codes, FSM state type and beat width for the SPI download receiver.
// DOWNLOAD_16BIT_EN selects 16-bit little-endian beats instead of 8-bit beats.
package spi_download_pkg;

   localparam logic [7:0] CMD_SET_INDEX = 8'h53;
   localparam logic [7:0] CMD_START     = 8'h54;
   localparam logic [7:0] CMD_END       = 8'h55;
   localparam logic [7:0] CMD_DATA      = 8'h56;

`ifdef DOWNLOAD_16BIT_EN
   localparam int DW        = 16;
   localparam int ADDR_STEP = 2;
`else
   localparam int DW        = 8;
   localparam int ADDR_STEP = 1;
`endif

   typedef enum logic [1:0] {
      CMD,
      IDX,
      DATA,
      IGNORE
   } rx_state_t;

   // State entered after the first byte of a transaction.
   function automatic rx_state_t state_after_cmd(input logic [7:0] code);
      rx_state_t nxt;
      case (code)
         CMD_SET_INDEX: nxt = IDX;
         CMD_DATA:      nxt = DATA;
         default:       nxt = IGNORE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Oversampling SPI slave front end: synchronizes SCK/DI/SS, counts bits and emits
// one-cycle byte_valid pulses with the assembled MSB-first byte.
module spi_byte_shifter (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       sck,
   input  logic       di,
   input  logic       ss_n,
   output logic       selected,
   output logic       byte_valid,
   output logic [7:0] byte_data
);

   logic [1:0] sck_sync;
   logic [1:0] di_sync;
   logic [1:0] ss_sync;
   logic       sck_q;
   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic       sck_rise;

   assign sck_rise = sck_sync[1] & ~sck_q;
   assign selected = ~ss_sync[1];

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sck_sync   <= 2'b00;
         di_sync    <= 2'b00;
         ss_sync    <= 2'b00;
         sck_q      <= 1'b0;
         bit_cnt    <= 3'd0;
         shift      <= 7'd0;
         byte_valid <= 1'b0;
         byte_data  <= 8'd0;
      end else begin
         sck_sync   <= {sck_sync[0], sck};
         di_sync    <= {di_sync[0], di};
         ss_sync    <= {ss_sync[0], ss_n};
         sck_q      <= sck_sync[1];
         byte_valid <= 1'b0;
         // Deselect discards any partial byte.
         if (ss_sync[1]) begin
            bit_cnt <= 3'd0;
         end else if (sck_rise) begin
            shift   <= {shift[5:0], di_sync[1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_valid <= 1'b1;
               byte_data  <= {shift, di_sync[1]};
            end
         end
      end
   end

endmodule

// File: rtl/spi_download_rx.sv
// File-download receiver on the data_io SPI channel: decodes commands and streams bytes
// to the core through a small FIFO. Define DOWNLOAD_16BIT_EN for 16-bit packed beats.
module spi_download_rx
   import spi_download_pkg::*;
#(
   parameter int AW         = 25,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          SPI_SCK,
   input  logic          SPI_DI,
   input  logic          SPI_SS2,
   input  logic          ioctl_wait,
   output logic          ioctl_download,
   output logic [7:0]    ioctl_index,
   output logic [AW-1:0] ioctl_addr,
   output logic [DW-1:0] ioctl_dout,
   output logic          ioctl_wr,
   output logic          ioctl_overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]   PTR_ONE  = (PW+1)'(1);
   localparam logic [AW-1:0] ADDR_INC = AW'(ADDR_STEP);

   logic            selected;
   logic            byte_valid;
   logic [7:0]      rx_byte;
   rx_state_t       state;
   logic            end_pending;
   logic            push_q;
   logic [DW-1:0]   push_word;
   logic [DW-1:0]   mem [FIFO_DEPTH];
   logic [PW:0]     wr_ptr;
   logic [PW:0]     rd_ptr;
   logic [AW-1:0]   next_addr;
   logic            cmd_byte;
   logic            start;
   logic            data_byte;
   logic            fifo_empty;
   logic            fifo_full;
   logic            pop;
   logic            push_store;
   logic            overflow_event;
   logic [DW-1:0]   pop_data;
   logic            pack_idle;

   spi_byte_shifter u_shifter (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .sck        (SPI_SCK),
      .di         (SPI_DI),
      .ss_n       (SPI_SS2),
      .selected   (selected),
      .byte_valid (byte_valid),
      .byte_data  (rx_byte)
   );

   assign cmd_byte  = byte_valid && selected && (state == CMD);
   assign start     = cmd_byte && (rx_byte == CMD_START);
   assign data_byte = byte_valid && selected && (state == DATA) && ioctl_download;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

   // An empty FIFO lets the incoming word fall straight through to the output.
   assign pop            = !ioctl_wait && !start && (!fifo_empty || push_q);
   assign pop_data       = fifo_empty ? push_word : mem[rd_ptr[PW-1:0]];
   assign push_store     = push_q && !(fifo_empty && pop) && (!fifo_full || pop);
   assign overflow_event = push_q && fifo_full && !pop;

`ifdef DOWNLOAD_16BIT_EN
   logic       half_valid;
   logic [7:0] low_byte;

   assign pack_idle = ~half_valid;

   always_ff @(posedge clk_sys) begin
      if (reset || start) begin
         push_q     <= 1'b0;
         push_word  <= '0;
         half_valid <= 1'b0;
         low_byte   <= 8'd0;
      end else begin
         push_q <= 1'b0;
         if (data_byte) begin
            if (half_valid) begin
               push_q     <= 1'b1;
               push_word  <= {rx_byte, low_byte};
               half_valid <= 1'b0;
            end else begin
               low_byte   <= rx_byte;
               half_valid <= 1'b1;
            end
         end else if (end_pending && half_valid) begin
            // Odd trailing byte goes out zero-padded before download ends.
            push_q     <= 1'b1;
            push_word  <= {8'h00, low_byte};
            half_valid <= 1'b0;
         end
      end
   end
`else
   assign pack_idle = 1'b1;

   always_ff @(posedge clk_sys) begin
      if (reset || start) begin
         push_q    <= 1'b0;
         push_word <= '0;
      end else begin
         push_q <= data_byte;
         if (data_byte) begin
            push_word <= rx_byte;
         end
      end
   end
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state          <= CMD;
         ioctl_download <= 1'b0;
         ioctl_index    <= 8'd0;
         ioctl_overflow <= 1'b0;
         end_pending    <= 1'b0;
      end else begin
         if (!selected) begin
            state <= CMD;
         end else if (byte_valid) begin
            case (state)
               CMD: state <= state_after_cmd(rx_byte);
               IDX: begin
                  if (!ioctl_download) begin
                     ioctl_index <= rx_byte;
                  end
                  state <= IGNORE;
               end
               default: state <= state;
            endcase
         end

         if (start) begin
            ioctl_download <= 1'b1;
            ioctl_overflow <= 1'b0;
            end_pending    <= 1'b0;
         end else begin
            if (cmd_byte && (rx_byte == CMD_END)) begin
               end_pending <= 1'b1;
            end else if (end_pending && fifo_empty && !push_q && pack_idle) begin
               end_pending    <= 1'b0;
               ioctl_download <= 1'b0;
            end
            if (overflow_event) begin
               ioctl_overflow <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push_store) begin
         mem[wr_ptr[PW-1:0]] <= push_word;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         next_addr  <= '0;
         ioctl_wr   <= 1'b0;
         ioctl_addr <= '0;
         ioctl_dout <= '0;
      end else begin
         ioctl_wr <= pop;
         if (start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            next_addr <= '0;
         end else begin
            if (push_store) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !fifo_empty) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (pop) begin
               ioctl_addr <= next_addr;
               ioctl_dout <= pop_data;
               next_addr  <= next_addr + ADDR_INC;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_download_rx.sv
// Directed bench for spi_download_rx: a default-width instance plus an AW=4 instance for
// address wrap, both fed the same SPI stream. Build with DOWNLOAD_16BIT_EN for the packed test.
module tb_spi_download_rx;

   localparam int AW  = 25;
   localparam int AWW = 4;
`ifdef DOWNLOAD_16BIT_EN
   localparam int DW = 16;
`else
   localparam int DW = 8;
`endif

   logic clk_sys = 1'b0;
   logic reset;
   logic sck;
   logic di;
   logic ss2;
   logic ioctl_wait;

   logic           ioctl_download;
   logic [7:0]     ioctl_index;
   logic [AW-1:0]  ioctl_addr;
   logic [DW-1:0]  ioctl_dout;
   logic           ioctl_wr;
   logic           ioctl_overflow;

   logic           w_download;
   logic [7:0]     w_index;
   logic [AWW-1:0] w_addr;
   logic [DW-1:0]  w_dout;
   logic           w_wr;
   logic           w_overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [AW+DW-1:0]  obs_q[$];
   logic [AWW+DW-1:0] obsw_q[$];
   int                obs_cyc[$];

   spi_download_rx #(.AW(AW), .FIFO_DEPTH(4)) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .SPI_SCK        (sck),
      .SPI_DI         (di),
      .SPI_SS2        (ss2),
      .ioctl_wait     (ioctl_wait),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wr       (ioctl_wr),
      .ioctl_overflow (ioctl_overflow)
   );

   spi_download_rx #(.AW(AWW), .FIFO_DEPTH(4)) dut_w (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .SPI_SCK        (sck),
      .SPI_DI         (di),
      .SPI_SS2        (ss2),
      .ioctl_wait     (ioctl_wait),
      .ioctl_download (w_download),
      .ioctl_index    (w_index),
      .ioctl_addr     (w_addr),
      .ioctl_dout     (w_dout),
      .ioctl_wr       (w_wr),
      .ioctl_overflow (w_overflow)
   );

   // Clock and beat capture
   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc++;

   always @(negedge clk_sys) begin
      if (ioctl_wr === 1'b1) begin
         obs_q.push_back({ioctl_addr, ioctl_dout});
         obs_cyc.push_back(cyc);
      end
      if (w_wr === 1'b1) begin
         obsw_q.push_back({w_addr, w_dout});
      end
   end

   // Driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic clear_obs();
      obs_q.delete();
      obsw_q.delete();
      obs_cyc.delete();
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         di = b[i];
         #40 sck = 1'b1;
         #40 sck = 1'b0;
      end
   endtask

   task automatic txn_start();
      ss2 = 1'b0;
      #80;
   endtask

   task automatic txn_end();
      #80 ss2 = 1'b1;
      #200;
   endtask

   task automatic send1(input logic [7:0] b);
      txn_start();
      spi_byte(b);
      txn_end();
   endtask

   // Scenarios
   task automatic test_reset();
      reset = 1'b1;
      sck = 1'b0;
      di = 1'b0;
      ss2 = 1'b1;
      ioctl_wait = 1'b0;
      idle(4);
      checks++;
      if (ioctl_download !== 1'b0) begin errors++; $display("FAIL reset_download: got %b expected 0", ioctl_download); end
      checks++;
      if (ioctl_index !== 8'h00) begin errors++; $display("FAIL reset_index: got %h expected 00", ioctl_index); end
      checks++;
      if (ioctl_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ioctl_addr); end
      checks++;
      if (ioctl_dout !== '0) begin errors++; $display("FAIL reset_dout: got %h expected 0", ioctl_dout); end
      checks++;
      if (ioctl_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", ioctl_wr); end
      checks++;
      if (ioctl_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", ioctl_overflow); end
      reset = 1'b0;
      idle(4);
   endtask

   task automatic test_index_download();
      logic [7:0] d [3];
      logic [AW+DW-1:0] exp_b;
      d = '{8'hA1, 8'hB2, 8'hC3};
      clear_obs();
      ioctl_wait = 1'b0;
      txn_start(); spi_byte(8'h53); spi_byte(8'h07); txn_end(); idle(2);
      checks++;
      if (ioctl_index !== 8'h07) begin errors++; $display("FAIL index_set: got %h expected 07", ioctl_index); end
      send1(8'h54); idle(2);
      checks++;
      if (ioctl_download !== 1'b1) begin errors++; $display("FAIL dl_start: got %b expected 1", ioctl_download); end
      txn_start(); spi_byte(8'h53); spi_byte(8'h09); txn_end(); idle(2);
      checks++;
      if (ioctl_index !== 8'h07) begin errors++; $display("FAIL index_locked: got %h expected 07", ioctl_index); end
      txn_start(); spi_byte(8'h56);
      for (int i = 0; i < 3; i++) spi_byte(d[i]);
      txn_end(); idle(5);
      send1(8'h55); idle(5);
      checks++;
      if (obs_q.size() != 3) begin errors++; $display("FAIL dl_count: got %0d expected 3", obs_q.size()); end
      for (int i = 0; i < 3; i++) begin
         exp_b = {AW'(i), DW'(d[i])};
         checks++;
         if (i >= obs_q.size()) begin errors++; $display("FAIL dl_beat%0d: got none expected %h", i, exp_b); end
         else if (obs_q[i] !== exp_b) begin errors++; $display("FAIL dl_beat%0d: got %h expected %h", i, obs_q[i], exp_b); end
      end
      checks++;
      if (ioctl_download !== 1'b0) begin errors++; $display("FAIL dl_end: got %b expected 0", ioctl_download); end
   endtask

   task automatic test_backpressure();
      logic [7:0] d [4];
      logic [AW+DW-1:0] exp_b;
      int rel;
      d = '{8'h10, 8'h20, 8'h30, 8'h40};
      clear_obs();
      ioctl_wait = 1'b1;
      send1(8'h54);
      txn_start(); spi_byte(8'h56);
      for (int i = 0; i < 4; i++) spi_byte(d[i]);
      txn_end(); idle(5);
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL bp_held: got %0d strobes expected 0", obs_q.size()); end
      rel = cyc;
      ioctl_wait = 1'b0;
      idle(8);
      checks++;
      if (obs_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", obs_q.size()); end
      for (int i = 0; i < 4; i++) begin
         exp_b = {AW'(i), DW'(d[i])};
         checks++;
         if (i >= obs_q.size()) begin errors++; $display("FAIL bp_beat%0d: got none expected %h", i, exp_b); end
         else begin
            if (obs_q[i] !== exp_b) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, obs_q[i], exp_b); end
            checks++;
            if (obs_cyc[i] != rel + 1 + i) begin errors++; $display("FAIL bp_cycle%0d: got %0d expected %0d", i, obs_cyc[i], rel + 1 + i); end
         end
      end
      checks++;
      if (ioctl_overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %b expected 0", ioctl_overflow); end
      send1(8'h55); idle(4);
   endtask

   task automatic test_overflow();
      logic [AW+DW-1:0] exp_b;
      clear_obs();
      ioctl_wait = 1'b1;
      send1(8'h54);
      txn_start(); spi_byte(8'h56);
      for (int i = 1; i <= 6; i++) spi_byte(8'(i));
      txn_end(); idle(5);
      checks++;
      if (ioctl_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ioctl_overflow); end
      ioctl_wait = 1'b0;
      idle(8);
      checks++;
      if (obs_q.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", obs_q.size()); end
      for (int i = 0; i < 4; i++) begin
         exp_b = {AW'(i), DW'(i + 1)};
         checks++;
         if (i >= obs_q.size()) begin errors++; $display("FAIL ovf_beat%0d: got none expected %h", i, exp_b); end
         else if (obs_q[i] !== exp_b) begin errors++; $display("FAIL ovf_beat%0d: got %h expected %h", i, obs_q[i], exp_b); end
      end
      checks++;
      if (ioctl_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ioctl_overflow); end
      send1(8'h55); idle(4);
      send1(8'h54); idle(2);
      checks++;
      if (ioctl_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ioctl_overflow); end
      clear_obs();
      txn_start(); spi_byte(8'h56); spi_byte(8'h77); txn_end(); idle(5);
      exp_b = {AW'(0), DW'(8'h77)};
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_b) begin
         errors++; $display("FAIL ovf_restart: got %0d beats first %h expected 1 beat %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_b);
      end
      send1(8'h55); idle(4);
   endtask

   task automatic test_abort();
      logic [AW+DW-1:0] exp_b;
      ioctl_wait = 1'b0;
      send1(8'h54);
      clear_obs();
      txn_start(); spi_byte(8'h56);
      for (int i = 0; i < 5; i++) begin
         di = 1'b1;
         #40 sck = 1'b1;
         #40 sck = 1'b0;
      end
      txn_end(); idle(5);
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL abort_nostrobe: got %0d strobes expected 0", obs_q.size()); end
      txn_start(); spi_byte(8'h56); spi_byte(8'h11); txn_end(); idle(5);
      exp_b = {AW'(0), DW'(8'h11)};
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_b) begin
         errors++; $display("FAIL abort_next: got %0d beats first %h expected 1 beat %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_b);
      end
      send1(8'h55); idle(4);
      checks++;
      if (ioctl_download !== 1'b0) begin errors++; $display("FAIL abort_end: got %b expected 0", ioctl_download); end
   endtask

   task automatic test_wrap();
      logic [AW+DW-1:0]  exp_b;
      logic [AWW+DW-1:0] exp_w;
      ioctl_wait = 1'b0;
      send1(8'h54);
      clear_obs();
      txn_start(); spi_byte(8'h56);
      for (int i = 0; i < 18; i++) spi_byte(8'(8'h80 + i));
      txn_end(); idle(5);
      checks++;
      if (obsw_q.size() != 18) begin errors++; $display("FAIL wrap_count: got %0d expected 18", obsw_q.size()); end
      for (int i = 0; i < 18; i++) begin
         exp_w = {AWW'(i % 16), DW'(8'h80 + i)};
         exp_b = {AW'(i), DW'(8'h80 + i)};
         checks++;
         if (i >= obsw_q.size()) begin errors++; $display("FAIL wrap_beat%0d: got none expected %h", i, exp_w); end
         else if (obsw_q[i] !== exp_w) begin errors++; $display("FAIL wrap_beat%0d: got %h expected %h", i, obsw_q[i], exp_w); end
         checks++;
         if (i >= obs_q.size()) begin errors++; $display("FAIL wide_beat%0d: got none expected %h", i, exp_b); end
         else if (obs_q[i] !== exp_b) begin errors++; $display("FAIL wide_beat%0d: got %h expected %h", i, obs_q[i], exp_b); end
      end
      send1(8'h55); idle(4);
   endtask

   task automatic test_back_to_back();
      logic [AW+DW-1:0] exp_b;
      ioctl_wait = 1'b1;
      send1(8'h54);
      clear_obs();
      txn_start(); spi_byte(8'h56); spi_byte(8'h5A); spi_byte(8'h5B); txn_end();
      send1(8'h54); idle(2);
      checks++;
      if (ioctl_download !== 1'b1) begin errors++; $display("FAIL b2b_download: got %b expected 1", ioctl_download); end
      ioctl_wait = 1'b0;
      idle(6);
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_flush: got %0d strobes expected 0", obs_q.size()); end
      txn_start(); spi_byte(8'h56); spi_byte(8'hC5); txn_end(); idle(5);
      exp_b = {AW'(0), DW'(8'hC5)};
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_b) begin
         errors++; $display("FAIL b2b_restart: got %0d beats first %h expected 1 beat %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_b);
      end
      send1(8'h55); idle(4);
      checks++;
      if (ioctl_download !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", ioctl_download); end
   endtask

   task automatic test_16bit();
      logic [AW+DW-1:0] exp_b;
      ioctl_wait = 1'b0;
      send1(8'h54);
      clear_obs();
      txn_start(); spi_byte(8'h56); spi_byte(8'h34); spi_byte(8'h12); spi_byte(8'h56); txn_end(); idle(5);
      exp_b = {AW'(0), DW'(16'h1234)};
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_b) begin
         errors++; $display("FAIL w16_pair: got %0d beats first %h expected 1 beat %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_b);
      end
      send1(8'h55); idle(6);
      exp_b = {AW'(2), DW'(16'h0056)};
      checks++;
      if (obs_q.size() != 2 || obs_q[1] !== exp_b) begin
         errors++; $display("FAIL w16_tail: got %0d beats last %h expected 2 beats ending %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : '0, exp_b);
      end
      checks++;
      if (ioctl_download !== 1'b0) begin errors++; $display("FAIL w16_end: got %b expected 0", ioctl_download); end
   endtask

   initial begin
      test_reset();
`ifdef DOWNLOAD_16BIT_EN
      test_16bit();
`else
      test_index_download();
      test_backpressure();
      test_overflow();
      test_abort();
      test_wrap();
      test_back_to_back();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_download_rx.md
Name: spi_download_rx

Overview:
- File-download receiver on the SPI_SS2 (data_io) channel from the board controller.
- Sits directly downstream of the board top-level SPI pins. Oversamples SPI_SCK/SPI_DI/SPI_SS2 in clk_sys and decodes command bytes.
- Streams downloaded bytes to the core as address/data/write-strobe beats, with back-pressure via ioctl_wait and a small FIFO.

Parameters:
- AW, 25, ioctl_addr width; address wraps modulo 2^AW.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >=2.

Ports:
- clk_sys  in  1  system clock; must be >=4x SPI_SCK frequency.
- reset  in  1  synchronous, active-high.
- SPI_SCK  in  1  controller SPI clock, asynchronous.
- SPI_DI  in  1  controller-to-FPGA data, MSB first, sampled on SCK rise.
- SPI_SS2  in  1  data_io select, active low, asynchronous.
- ioctl_wait  in  1  core back-pressure; 1 = hold off ioctl_wr.
- ioctl_download  out  1  download in progress.
- ioctl_index  out  8  file/slot index from the last set-index command.
- ioctl_addr  out  AW  address of the current beat.
- ioctl_dout  out  8  data of the current beat (16 with DOWNLOAD_16BIT_EN).
- ioctl_wr  out  1  one-cycle write strobe.
- ioctl_overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0. Reset also clears FIFO, FSM, bit counter and synchronizers. Reset mid-transfer discards partial bytes and buffered data.
- Input sync: 2-FF synchronizer on each of SCK, DI and SS2. sck_rise = sync_sck & ~sck_q.
- While SS2 is high, the bit counter is held at 0.
- On each sck_rise with SS2 low:
  - shift DI in;
  - on the 8th bit, byte_valid pulses for 1 cycle (cycle N) and the counter returns to 0.
- FSM, per SS2-low transaction; SS2 high forces CMD:
  - CMD: first byte is the command.
    - 0x53 -> IDX.
    - 0x54 -> start: download=1, next write address = 0, overflow cleared, FIFO flushed; -> IGNORE.
    - 0x55 -> set end_pending; -> IGNORE.
    - 0x56 -> DATA.
    - Other codes -> IGNORE.
  - IDX: byte -> ioctl_index; -> IGNORE. Accepted only while download=0; otherwise the byte is ignored.
  - DATA: every byte is pushed to the FIFO at N+1 if download=1, else dropped silently. Stays in DATA until SS2 rises.
  - IGNORE: consumes bytes until SS2 rises.
- FIFO full when a byte arrives: byte dropped, ioctl_overflow=1 (sticky until the next 0x54 or reset).
- Output:
  - In a cycle where FIFO is non-empty and ioctl_wait=0, pop the FIFO.
  - Next cycle: ioctl_wr=1, ioctl_dout=popped data, ioctl_addr=write address.
  - The write address increments by 1 (by 2 in 16-bit mode) after each beat and wraps to 0 past 2^AW-1.
  - ioctl_dout/ioctl_addr hold until the next beat.
  - Empty FIFO, write into it at N+1 -> ioctl_wr at N+2 at the earliest.
  - Sustained rate: one beat per cycle.
- ioctl_wait=1: no pops; already-issued strobes are not repeated. Strobes resume the cycle after wait drops.
- Simultaneous push and pop on a full FIFO: the push is accepted (no overflow).
- End: download falls in the first cycle where end_pending=1 and the FIFO is empty. end_pending is then cleared.
- Back-to-back: 0x54 received while download=1 restarts cleanly (address 0, FIFO flushed).

Optional Feature:
- DOWNLOAD_16BIT_EN defined:
  - Pairs of bytes are packed little-endian (first byte in [7:0]); ioctl_dout is 16 bits.
  - A beat issues per complete pair; the address steps by 2.
  - An odd trailing byte at end (0x55) is flushed with [15:8]=0x00 before download falls.
- Not defined: 8-bit beats as described above.

Decomposition:
- Package spi_download_pkg:
  - command localparams CMD_SET_INDEX=8'h53, CMD_START=8'h54, CMD_END=8'h55, CMD_DATA=8'h56;
  - FSM state typedef enum {CMD, IDX, DATA, IGNORE}.
- Sub-module spi_byte_shifter: synchronizers, edge detect, bit counter, byte_valid/byte output. Testable alone.

Test Plan:
- Index then download: send SS2 txn [0x53,0x07], then [0x54], [0x56,0xA1,0xB2,0xC3], [0x55], ioctl_wait=0 -> index=0x07; three strobes with addr 0/1/2 and data A1/B2/C3; download falls after the third beat.
- Back-pressure: hold ioctl_wait=1 while sending 4 data bytes (FIFO_DEPTH=4), then release -> no strobe while held; 4 strobes on consecutive cycles after release; overflow=0.
- Overflow: wait=1, send 6 data bytes -> bytes 5 and 6 dropped, ioctl_overflow=1; next 0x54 clears it and the address restarts at 0.
- Abort: SS2 rises after 5 bits of a data byte -> no strobe, FSM back to CMD. Next txn [0x56,0x11] while download=1 -> one strobe of 0x11.
- Wrap: AW=4, 18 bytes -> addresses 0..15, 0, 1.
- DOWNLOAD_16BIT_EN: bytes 0x34,0x12,0x56 then 0x55 -> beats 16'h1234 @0 and 16'h0056 @2; download then falls.
